serial_rx: RTL and testbench
============================

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter Width, default 8: number of data bits per frame.
REQ-002 Parameter TimerWidth, default 8: bit period P = 2^TimerWidth clk cycles; half period H = 2^(TimerWidth-1).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 ack  input  1  consumer acknowledge; clears valid.
REQ-007 Q  output  Width  last received data word.
REQ-008 valid  output  1  Q holds unacknowledged data (level).
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: new word overwrote unacknowledged Q.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 Frame format SHALL be 1 start bit (0), Width data bits LSB first, then at least 1 stop bit (1); the receiver SHALL check exactly one stop bit.
REQ-013 rx SHALL pass a 2-flop synchronizer; rxs denotes its output. All logic below uses rxs only.
REQ-014 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; the bit timer is TimerWidth wide and the bit counter is wide enough to hold Width-1.
REQ-015 IDLE: rxs==0 at cycle t0 -> START, timer cleared.
REQ-016 START: at t0+H sample rxs; 0 -> DATA with timer and bit counter cleared; 1 -> IDLE (false start, no outputs change).
REQ-017 DATA: data bit i SHALL be sampled at t0+H+(i+1)*P into shift register position i; after bit Width-1 -> STOP.
REQ-018 STOP: sample at t0+H+(Width+1)*P; 1 -> load Q, set valid, -> IDLE; 0 -> pulse frame_err, discard data, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: stay until rxs==1, then -> IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-020 Latency: Q/valid SHALL update on the cycle after the stop sample.
REQ-021 ack==1 with valid==1 SHALL clear valid next cycle; ack with valid==0 has no effect.
REQ-022 Word completes while valid==1 and ack==0: Q overwritten, valid stays 1, overrun pulses.
REQ-023 Word completes in the same cycle as ack: Q loaded, valid stays 1, no overrun.
REQ-024 Return to IDLE after the stop sample SHALL allow a new start edge to be detected immediately (back-to-back frames from SerialTx at equal P).
REQ-025 Timer SHALL wrap modulo 2^TimerWidth; no other arithmetic overflow is permitted.

Reset
REQ-026 rst low SHALL asynchronously force: state IDLE, Q=0, valid=0, frame_err=0, overrun=0, busy=0, timer=0, bit counter=0, synchronizer flops=1.
REQ-027 Reset mid-frame SHALL abort the frame with no valid, frame_err or overrun; after release the next falling edge on rxs starts a fresh frame.

Structure
REQ-028 State encodings SHALL be constants in a shared include-guarded header, reusable by other io blocks.
REQ-029 The synchronizer SHALL be a separate sub-module serial_sync (2 flops, reset value 1).

Verification (TimerWidth=4, P=16, H=8, Width=8)
REQ-030 SerialTx at matching parameters sends 0xA5 -> Q=0xA5, valid=1, frame_err=0, overrun=0; ack -> valid=0 next cycle.
REQ-031 rx low for 4 cycles then high -> false start, busy returns to 0, valid stays 0.
REQ-032 Frame 0x3C with stop bit forced 0 and line held low for 3*P -> one frame_err pulse, valid=0, busy until rx high.
REQ-033 Back-to-back 0x11, 0x22 without ack -> Q=0x22, valid=1, one overrun pulse; repeat with ack in completion cycle -> no overrun.
REQ-034 rst asserted mid DATA bit 4 of 0xFF, released, then 0x0F sent -> only Q=0x0F reported, no frame_err.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared serial-io definitions: receiver state encodings and sizing helpers.
// Include-guarded so several io blocks can pull it into one compile.
`ifndef SERIAL_RX_PKG_SV
`define SERIAL_RX_PKG_SV
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int SYNC_STAGES = 2;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`endif

// File: rtl/serial_rx_sync.sv
// Metastability synchronizer for the serial line; resets to the idle-high level.
module serial_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '1;
    else      sync_pipe <= {sync_pipe[STAGES-2:0], d};
  end

  assign q = sync_pipe[STAGES-1];

endmodule

// File: rtl/serial_rx.sv
// Async serial receiver: 1 start, Width data bits LSB first, 1 checked stop bit.
// Bits are sampled mid-period off a free-running, wrapping bit timer.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int Width      = 8,
  parameter int TimerWidth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic             ack,
  output logic [Width-1:0] Q,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = cnt_w(Width);
  localparam logic [TimerWidth-1:0] T_HALF_END = {1'b0, {(TimerWidth-1){1'b1}}};
  localparam logic [TimerWidth-1:0] T_FULL_END = '1;
  localparam logic [CW-1:0]         LAST_BIT   = CW'(Width-1);

  logic rxs;

  serial_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  rx_state_e             state, state_n;
  logic [TimerWidth-1:0] timer, timer_n;
  logic [CW-1:0]         bitcnt, bitcnt_n;
  logic [Width-1:0]      shreg, shreg_n;
  logic [Width-1:0]      q_n;
  logic                  valid_n, ferr_n, ovr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      Q         <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      Q         <= q_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    timer_n  = timer + 1'b1;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    q_n      = Q;
    valid_n  = valid;
    ferr_n   = 1'b0;
    ovr_n    = 1'b0;

    if (ack && valid) valid_n = 1'b0;

    case (state)
      ST_IDLE: begin
        timer_n  = '0;
        bitcnt_n = '0;
        if (!rxs) state_n = ST_START;
      end
      ST_START: begin
        if (timer == T_HALF_END) begin
          timer_n  = '0;
          bitcnt_n = '0;
          state_n  = rxs ? ST_IDLE : ST_DATA;
        end
      end
      // Timer wraps from T_FULL_END to 0, so consecutive samples stay one period apart.
      ST_DATA: begin
        if (timer == T_FULL_END) begin
          shreg_n[bitcnt] = rxs;
          if (bitcnt == LAST_BIT) state_n  = ST_STOP;
          else                    bitcnt_n = bitcnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (timer == T_FULL_END) begin
          if (rxs) begin
            q_n     = shreg;
            valid_n = 1'b1;
            ovr_n   = valid && !ack;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_HIGH;
          end
        end
      end
      // A break keeps us here, so it reports a single frame error.
      ST_WAIT_HIGH: begin
        timer_n = '0;
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Randomized self-checking bench for serial_rx at P=16, Width=8.
module tb_serial_rx;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int P  = 16;
  localparam int H  = 8;
  // rx driven just after edge 0: two sync flops, then the stop sample cycle.
  localparam int SAMPLE_OFF = 2 + H + (W + 1) * P;
  localparam int LOAD_OFF   = SAMPLE_OFF + 1;
  localparam int FRAME      = (W + 2) * P;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx  = 1'b1;
  logic         ack = 1'b0;
  logic [W-1:0] Q;
  logic         valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, busy_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  int start_cyc = 0;
  logic valid_q = 1'b0;
  logic [W-1:0] q_m = '0;

  serial_rx #(.Width(W), .TimerWidth(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ack       (ack),
    .Q         (Q),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun)   ov_cnt <= ov_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (valid && !valid_q) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    valid_q <= valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transmit one frame, one bit per P cycles; optional ack pulse and early abort.
  task automatic send(input logic [W-1:0] d, input logic stopv,
                      input int ack_at, input int abort_at);
    logic [W+1:0] bits;
    bits = {stopv, d, 1'b0};
    start_cyc = cyc;
    for (int c = 0; c < FRAME; c++) begin
      if (c == abort_at) begin
        ack = 1'b0;
        return;
      end
      rx  = bits[c / P];
      ack = (c == ack_at);
      tick();
    end
    ack = 1'b0;
    rx  = stopv;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx = 1'b1; ack = 1'b0;
    repeat (3) tick();
    total++;
    if (Q !== '0 || valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: Q=%h valid=%b ferr=%b ovr=%b busy=%b, want all 0", Q, valid, frame_err, overrun, busy);
    end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int fe0, ov0, r0;
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    send(8'hA5, 1'b1, -1, -1);
    q_m = 8'hA5;
    total++;
    if (Q !== 8'hA5 || valid !== 1'b1) begin
      bad++; $display("FAIL basic_word: Q=%h valid=%b, want a5 1", Q, valid);
    end
    total++;
    if (fe_cnt - fe0 != 0 || ov_cnt - ov0 != 0 || rise_cnt - r0 != 1) begin
      bad++; $display("FAIL basic_pulses: ferr=%0d ovr=%0d rises=%0d, want 0 0 1", fe_cnt - fe0, ov_cnt - ov0, rise_cnt - r0);
    end
    total++;
    if (rise_cyc - start_cyc != LOAD_OFF) begin
      bad++; $display("FAIL basic_latency: %0d cycles, want %0d", rise_cyc - start_cyc, LOAD_OFF);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL basic_ack: valid=%b, want 0", valid);
    end
  endtask

  task automatic test_false_start();
    int fe0, b0;
    fe0 = fe_cnt; b0 = busy_cnt;
    rx = 1'b0; repeat (4) tick();
    rx = 1'b1; repeat (20) tick();
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || Q !== q_m || fe_cnt != fe0 || busy_cnt == b0) begin
      bad++;
      $display("FAIL false_start: busy=%b valid=%b Q=%h ferr=%0d busycyc=%0d, want 0 0 %h 0 >0",
               busy, valid, Q, fe_cnt - fe0, busy_cnt - b0, q_m);
    end
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send(8'h3C, 1'b0, -1, -1);
    repeat (3 * P) tick();
    total++;
    if (fe_cnt - fe0 != 1 || valid !== 1'b0 || busy !== 1'b1 || Q !== q_m) begin
      bad++;
      $display("FAIL frame_err_break: ferr=%0d valid=%b busy=%b Q=%h, want 1 0 1 %h", fe_cnt - fe0, valid, busy, Q, q_m);
    end
    rx = 1'b1;
    repeat (4) tick();
    total++;
    if (busy !== 1'b0 || fe_cnt - fe0 != 1) begin
      bad++; $display("FAIL frame_err_release: busy=%b ferr=%0d, want 0 1", busy, fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back();
    int ov0;
    ov0 = ov_cnt;
    send(8'h11, 1'b1, -1, -1);
    send(8'h22, 1'b1, -1, -1);
    q_m = 8'h22;
    total++;
    if (Q !== 8'h22 || valid !== 1'b1 || ov_cnt - ov0 != 1) begin
      bad++; $display("FAIL b2b_overrun: Q=%h valid=%b ovr=%0d, want 22 1 1", Q, valid, ov_cnt - ov0);
    end
    ack = 1'b1; tick(); ack = 1'b0;
    ov0 = ov_cnt;
    send(8'h11, 1'b1, -1, -1);
    send(8'h22, 1'b1, SAMPLE_OFF, -1);
    total++;
    if (Q !== 8'h22 || valid !== 1'b1 || ov_cnt - ov0 != 0) begin
      bad++; $display("FAIL b2b_ack_same_cycle: Q=%h valid=%b ovr=%0d, want 22 1 0", Q, valid, ov_cnt - ov0);
    end
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int fe0, ov0, r0;
    send(8'hFF, 1'b1, -1, 5 * P + 5);
    rst = 1'b0;
    #1;
    q_m = '0;
    total++;
    if (busy !== 1'b0 || valid !== 1'b0 || Q !== '0) begin
      bad++; $display("FAIL reset_async: busy=%b valid=%b Q=%h, want 0 0 00", busy, valid, Q);
    end
    tick();
    rst = 1'b1; rx = 1'b1;
    repeat (2) tick();
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_cnt;
    send(8'h0F, 1'b1, -1, -1);
    q_m = 8'h0F;
    total++;
    if (Q !== 8'h0F || valid !== 1'b1 || fe_cnt != fe0 || ov_cnt != ov0 || rise_cnt - r0 != 1) begin
      bad++;
      $display("FAIL reset_mid_frame: Q=%h valid=%b ferr=%0d ovr=%0d rises=%0d, want 0f 1 0 0 1",
               Q, valid, fe_cnt - fe0, ov_cnt - ov0, rise_cnt - r0);
    end
  endtask

  // Model: each good frame replaces the word; overrun iff the old word was never acked.
  task automatic test_random();
    logic         valid_m;
    logic [W-1:0] d;
    int           gap, ov0, fe0, ov_m;
    ack = 1'b1; tick(); ack = 1'b0;
    valid_m = 1'b0;
    for (int i = 0; i < 12; i++) begin
      d   = W'($urandom_range(0, 255));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 30));
      ov0 = ov_cnt; fe0 = fe_cnt;
      repeat (gap) tick();
      send(d, 1'b1, -1, -1);
      ov_m    = valid_m ? 1 : 0;
      q_m     = d;
      valid_m = 1'b1;
      total++;
      if (Q !== q_m || valid !== valid_m) begin
        bad++; $display("FAIL rand_word[%0d]: Q=%h valid=%b, want %h %b", i, Q, valid, q_m, valid_m);
      end
      total++;
      if (ov_cnt - ov0 != ov_m || fe_cnt != fe0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_flags[%0d]: ovr=%0d ferr=%0d busy=%b, want %0d 0 0", i, ov_cnt - ov0, fe_cnt - fe0, busy, ov_m);
      end
      if ($urandom_range(0, 1) == 1) begin
        ack = 1'b1; tick(); ack = 1'b0;
        valid_m = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
          ack = 1'b1; tick(); ack = 1'b0;
        end
        total++;
        if (valid !== valid_m || Q !== q_m) begin
          bad++; $display("FAIL rand_ack[%0d]: valid=%b Q=%h, want %b %h", i, valid, Q, valid_m, q_m);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
